hwpe_ctrl_offload_ctrl: RTL
===========================

HWPE_CTRL_OFFLOAD_CTRL -- requirements
Module: hwpe_ctrl_offload_ctrl

Interface
REQ-001 SHALL have parameter N_CONTEXT, default REGFILE_N_CONTEXT: number of job contexts, a power of two, 1..4.
REQ-002 SHALL have parameter ID_WIDTH, default 16: peripheral requester-ID width.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port cfg_req_i, input, 1 bit: peripheral request.
REQ-006 SHALL have port cfg_add_i, input, 32 bits: byte address; word index = add[LOG_REGS_MC+1:2].
REQ-007 SHALL have port cfg_wen_i, input, 1 bit: 0 = write, 1 = read.
REQ-008 SHALL have port cfg_be_i, input, 4 bits: byte enables.
REQ-009 SHALL have port cfg_data_i, input, 32 bits: write data.
REQ-010 SHALL have port cfg_id_i, input, ID_WIDTH bits: requester ID.
REQ-011 SHALL have port cfg_gnt_o, output, 1 bit: grant; equals cfg_req_i, combinational.
REQ-012 SHALL have port cfg_r_valid_o, output, 1 bit: response valid.
REQ-013 SHALL have port cfg_r_data_o, output, 32 bits: response data; passes regfile_out_i.rdata through.
REQ-014 SHALL have port cfg_r_id_o, output, ID_WIDTH bits: response ID.
REQ-015 SHALL have port regfile_in_o, output, regfile_in_t: addr, wdata, be, wren and src toward the register file.
REQ-016 SHALL have port regfile_out_i, input, regfile_out_t: read data returned by the register file.
REQ-017 SHALL have port flags_o, output, flags_regfile_t: decode flags and context state.
REQ-018 SHALL have port done_i, input, 1 bit: engine job-complete pulse.
REQ-019 SHALL have port start_o, output, 1 bit: one-cycle engine start pulse.
REQ-020 SHALL have port clear_o, output, 1 bit: one-cycle soft-clear pulse.
REQ-021 SHALL have port evt_o, output, 1 bit: completion event, equal to flags_o.true_done.

Function
REQ-022 SHALL decode combinationally: reg = word[LOG_REGS-1:0]; cxt = word[LOG_REGS_MC-1:LOG_REGS]; is_mandatory = reg < N_MANDATORY_REGS; is_contexted = reg >= N_MANDATORY_REGS+N_RESERVED_REGS+N_MAX_GENERIC_REGS.
REQ-023 SHALL assert is_read for a granted read; wren for a granted write; is_testset for a granted read of reg 1; is_trigger for a granted write of reg 0 by the lock owner.
REQ-024 SHALL assert cfg_r_valid_o exactly 1 cycle after every grant, for reads and writes; cfg_r_id_o SHALL equal the ID captured at the grant.
REQ-025 SHALL keep a lock (bit plus owner ID): testset with lock clear and n_busy<N_CONTEXT SHALL set the lock to cfg_id_i.
REQ-026 SHALL drive flags_o.is_critical = lock set, and flags_o.full_context = (n_busy==N_CONTEXT).
REQ-027 SHALL, on a trigger: clear the lock, set pointer_context = pointer_context+1 mod N_CONTEXT, and set n_busy = n_busy+1.
REQ-028 SHALL ignore a write to reg 0 from a non-owner or with no lock held (write completes, no state change).
REQ-029 SHALL implement an engine FSM with states IDLE, START, RUN.
- IDLE->START when n_busy>0.
- START: start_o=1 for one cycle, then RUN.
- RUN->START when done_i and n_busy>1; RUN->IDLE when done_i and n_busy==1.
REQ-030 SHALL, on done_i in RUN: pulse true_done for 1 cycle, decrement n_busy, and set running_context = running_context+1 mod N_CONTEXT; done_i outside RUN SHALL be ignored.
REQ-031 SHALL leave n_busy unchanged when a trigger and a done occur in the same cycle, and update both pointers.
REQ-032 SHALL treat a write to reg 5 as a soft clear: clear_o=1 next cycle, and every register returns to its reset value in that cycle; a soft clear SHALL take priority over any simultaneous trigger or done.
REQ-033 SHALL drive ext_we = 0 constantly.

Reset
REQ-034 SHALL on rst_ni=0 set: FSM IDLE, n_busy=0, pointer_context=0, running_context=0, lock clear, owner 0, and the outputs cfg_r_valid_o, start_o, clear_o, evt_o and true_done all 0.
REQ-035 SHALL abandon a job running during reset; no start_o or evt_o SHALL follow the reset release.

Structure
REQ-036 SHALL take regfile_in_t, regfile_out_t, flags_regfile_t, N_MANDATORY_REGS, N_RESERVED_REGS, N_MAX_GENERIC_REGS, REGFILE_N_REGISTERS and the register indices (trigger 0, acquire 1, soft clear 5) from hwpe_ctrl_package; no new package content is required.
REQ-037 SHALL be a single module without sub-modules; LOG_REGS and LOG_REGS_MC SHALL be local parameters.

Verification
REQ-038 Case: ID 3 reads reg 1 -> testset asserted, lock owner 3, r_valid and r_id=3 one cycle later.
REQ-039 Case: ID 5 reads reg 1 while locked -> is_critical=1, lock unchanged.
REQ-040 Case: owner 3 writes reg 0 -> lock cleared, pointer_context 0->1, n_busy=1, start_o pulses 2 cycles later.
REQ-041 Case: N_CONTEXT=2, two acquire+trigger pairs -> full_context=1; a third testset leaves the lock clear.
REQ-042 Case: done_i and a trigger in the same cycle in RUN with n_busy=2 -> n_busy stays 2, evt_o=1, start_o the next cycle.
REQ-043 Case: write reg 5 during RUN -> clear_o=1; the next cycle FSM is IDLE, n_busy=0, and done_i is then ignored.

Source files
------------

// File: rtl/hwpe_ctrl_package.sv
// Shared register-file types and constants for the HWPE control slice.
// Mandatory register map: 0 trigger, 1 acquire, 5 soft clear.
package hwpe_ctrl_package;

    localparam int unsigned REGFILE_N_CONTEXT           = 2;
    localparam int unsigned N_MANDATORY_REGS            = 7;
    localparam int unsigned N_RESERVED_REGS             = 1;
    localparam int unsigned N_MAX_GENERIC_REGS          = 8;
    localparam int unsigned N_MAX_IO_REGS               = 48;
    localparam int unsigned REGFILE_N_REGISTERS         = 64;
    localparam int unsigned REGFILE_MANDATORY_TRIGGER   = 0;
    localparam int unsigned REGFILE_MANDATORY_ACQUIRE   = 1;
    localparam int unsigned REGFILE_MANDATORY_SOFTCLEAR = 5;
    localparam int unsigned REGFILE_SRC_WIDTH           = 16;
    localparam int unsigned REGFILE_CXT_WIDTH           = 2;

    typedef enum logic [1:0] {
        CTRL_IDLE  = 2'd0,
        CTRL_START = 2'd1,
        CTRL_RUN   = 2'd2
    } ctrl_fsm_e;

    typedef struct packed {
        logic [31:0]                  addr;
        logic [31:0]                  wdata;
        logic [3:0]                   be;
        logic                         wren;
        logic [REGFILE_SRC_WIDTH-1:0] src;
    } regfile_in_t;

    typedef struct packed {
        logic [31:0] rdata;
    } regfile_out_t;

    typedef struct packed {
        logic                         is_mandatory;
        logic                         is_contexted;
        logic                         is_read;
        logic                         is_testset;
        logic                         is_trigger;
        logic                         is_critical;
        logic                         true_done;
        logic                         full_context;
        logic                         ext_we;
        logic [REGFILE_CXT_WIDTH-1:0] cxt;
        logic [REGFILE_CXT_WIDTH-1:0] pointer_context;
        logic [REGFILE_CXT_WIDTH-1:0] running_context;
    } flags_regfile_t;

endpackage

// File: rtl/hwpe_ctrl_offload_ctrl.sv
// Offload controller: peripheral decode, job-context lock, and engine
// start/done sequencing for a hardware processing engine.
//
// state      | meaning
// CTRL_IDLE  | no queued job, engine quiet
// CTRL_START | start_o pulse for the oldest queued job
// CTRL_RUN   | engine busy, waiting for done_i
module hwpe_ctrl_offload_ctrl
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned N_CONTEXT = REGFILE_N_CONTEXT,
    parameter int unsigned ID_WIDTH  = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cfg_req_i,
    input  logic [31:0]         cfg_add_i,
    input  logic                cfg_wen_i,
    input  logic [3:0]          cfg_be_i,
    input  logic [31:0]         cfg_data_i,
    input  logic [ID_WIDTH-1:0] cfg_id_i,
    output logic                cfg_gnt_o,
    output logic                cfg_r_valid_o,
    output logic [31:0]         cfg_r_data_o,
    output logic [ID_WIDTH-1:0] cfg_r_id_o,
    output regfile_in_t         regfile_in_o,
    input  regfile_out_t        regfile_out_i,
    output flags_regfile_t      flags_o,
    input  logic                done_i,
    output logic                start_o,
    output logic                clear_o,
    output logic                evt_o
);

    localparam int unsigned LOG_REGS    = $clog2(REGFILE_N_REGISTERS);
    localparam int unsigned LOG_CXT     = $clog2(N_CONTEXT);
    localparam int unsigned LOG_REGS_MC = LOG_REGS + LOG_CXT;
    localparam int unsigned CXT_W       = (LOG_CXT > 0) ? LOG_CXT : 1;
    localparam int unsigned BUSY_W      = $clog2(N_CONTEXT + 1);

    localparam logic [LOG_REGS-1:0] REG_TRIGGER   = LOG_REGS'(REGFILE_MANDATORY_TRIGGER);
    localparam logic [LOG_REGS-1:0] REG_ACQUIRE   = LOG_REGS'(REGFILE_MANDATORY_ACQUIRE);
    localparam logic [LOG_REGS-1:0] REG_SOFTCLEAR = LOG_REGS'(REGFILE_MANDATORY_SOFTCLEAR);
    localparam logic [LOG_REGS-1:0] N_MAND        = LOG_REGS'(N_MANDATORY_REGS);
    localparam logic [LOG_REGS-1:0] FIRST_CXT_REG =
        LOG_REGS'(N_MANDATORY_REGS + N_RESERVED_REGS + N_MAX_GENERIC_REGS);
    localparam logic [BUSY_W-1:0]   BUSY_FULL     = BUSY_W'(N_CONTEXT);
    localparam logic [CXT_W-1:0]    CXT_LAST      = CXT_W'(N_CONTEXT - 1);

    ctrl_fsm_e              state_q, state_d;
    logic [BUSY_W-1:0]      n_busy_q, n_busy_d;
    logic [CXT_W-1:0]       ptr_q, ptr_d;
    logic [CXT_W-1:0]       run_q, run_d;
    logic                   lock_q, lock_d;
    logic [ID_WIDTH-1:0]    owner_q, owner_d;
    logic                   start_q, start_d;
    logic                   clear_q, clear_d;
    logic                   true_done_q, true_done_d;
    logic                   r_valid_q, r_valid_d;
    logic [ID_WIDTH-1:0]    r_id_q, r_id_d;

    logic [LOG_REGS-1:0]          reg_idx;
    logic [REGFILE_CXT_WIDTH-1:0] cxt_idx;
    logic                         wr_grant, rd_grant;
    logic                         is_testset, is_trigger, is_softclr, do_done;

    function automatic logic [CXT_W-1:0] cxt_inc(input logic [CXT_W-1:0] c);
        return (c == CXT_LAST) ? '0 : c + 1'b1;
    endfunction

    assign reg_idx = cfg_add_i[LOG_REGS+1:2];

    generate
        if (LOG_CXT > 0) begin : g_cxt
            assign cxt_idx = REGFILE_CXT_WIDTH'(cfg_add_i[LOG_REGS_MC+1:LOG_REGS+2]);
        end else begin : g_no_cxt
            assign cxt_idx = '0;
        end
    endgenerate

    assign wr_grant   = cfg_req_i & ~cfg_wen_i;
    assign rd_grant   = cfg_req_i & cfg_wen_i;
    assign is_testset = rd_grant && (reg_idx == REG_ACQUIRE);
    assign is_trigger = wr_grant && (reg_idx == REG_TRIGGER) && lock_q && (owner_q == cfg_id_i);
    assign is_softclr = wr_grant && (reg_idx == REG_SOFTCLEAR);
    assign do_done    = (state_q == CTRL_RUN) && done_i;

    always_comb begin
        state_d     = state_q;
        n_busy_d    = n_busy_q;
        ptr_d       = ptr_q;
        run_d       = run_q;
        lock_d      = lock_q;
        owner_d     = owner_q;
        start_d     = 1'b0;
        clear_d     = 1'b0;
        true_done_d = 1'b0;
        r_valid_d   = cfg_req_i;
        r_id_d      = cfg_req_i ? cfg_id_i : r_id_q;

        if (is_testset && !lock_q && (n_busy_q < BUSY_FULL)) begin
            lock_d  = 1'b1;
            owner_d = cfg_id_i;
        end
        if (is_trigger) begin
            lock_d = 1'b0;
            ptr_d  = cxt_inc(ptr_q);
        end
        if (do_done) begin
            true_done_d = 1'b1;
            run_d       = cxt_inc(run_q);
        end

        case ({is_trigger, do_done})
            2'b10:   n_busy_d = n_busy_q + 1'b1;
            2'b01:   n_busy_d = n_busy_q - 1'b1;
            default: n_busy_d = n_busy_q;
        endcase

        // Going back to START straight from RUN also covers a same-cycle trigger
        // that keeps the queue non-empty.
        case (state_q)
            CTRL_IDLE: begin
                if (n_busy_q != '0) begin
                    state_d = CTRL_START;
                    start_d = 1'b1;
                end
            end
            CTRL_START: state_d = CTRL_RUN;
            CTRL_RUN: begin
                if (do_done) begin
                    if (n_busy_d != '0) begin
                        state_d = CTRL_START;
                        start_d = 1'b1;
                    end else begin
                        state_d = CTRL_IDLE;
                    end
                end
            end
            default: state_d = CTRL_IDLE;
        endcase

        if (is_softclr) begin
            state_d     = CTRL_IDLE;
            n_busy_d    = '0;
            ptr_d       = '0;
            run_d       = '0;
            lock_d      = 1'b0;
            owner_d     = '0;
            start_d     = 1'b0;
            true_done_d = 1'b0;
            clear_d     = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= CTRL_IDLE;
            n_busy_q    <= '0;
            ptr_q       <= '0;
            run_q       <= '0;
            lock_q      <= 1'b0;
            owner_q     <= '0;
            start_q     <= 1'b0;
            clear_q     <= 1'b0;
            true_done_q <= 1'b0;
            r_valid_q   <= 1'b0;
            r_id_q      <= '0;
        end else begin
            state_q     <= state_d;
            n_busy_q    <= n_busy_d;
            ptr_q       <= ptr_d;
            run_q       <= run_d;
            lock_q      <= lock_d;
            owner_q     <= owner_d;
            start_q     <= start_d;
            clear_q     <= clear_d;
            true_done_q <= true_done_d;
            r_valid_q   <= r_valid_d;
            r_id_q      <= r_id_d;
        end
    end

    assign cfg_gnt_o     = cfg_req_i;
    assign cfg_r_valid_o = r_valid_q;
    assign cfg_r_data_o  = regfile_out_i.rdata;
    assign cfg_r_id_o    = r_id_q;
    assign start_o       = start_q;
    assign clear_o       = clear_q;
    assign evt_o         = true_done_q;

    always_comb begin
        regfile_in_o       = '0;
        regfile_in_o.addr  = cfg_add_i;
        regfile_in_o.wdata = cfg_data_i;
        regfile_in_o.be    = cfg_be_i;
        regfile_in_o.wren  = wr_grant;
        regfile_in_o.src   = REGFILE_SRC_WIDTH'(cfg_id_i);
    end

    always_comb begin
        flags_o                 = '0;
        flags_o.is_mandatory    = reg_idx < N_MAND;
        flags_o.is_contexted    = reg_idx >= FIRST_CXT_REG;
        flags_o.is_read         = rd_grant;
        flags_o.is_testset      = is_testset;
        flags_o.is_trigger      = is_trigger;
        flags_o.is_critical     = lock_q;
        flags_o.true_done       = true_done_q;
        flags_o.full_context    = (n_busy_q == BUSY_FULL);
        flags_o.ext_we          = 1'b0;
        flags_o.cxt             = cxt_idx;
        flags_o.pointer_context = REGFILE_CXT_WIDTH'(ptr_q);
        flags_o.running_context = REGFILE_CXT_WIDTH'(run_q);
    end

endmodule
